axis_out_packer: RTL and testbench

Runtime-configurable output packer between the processing engine's per-beat row output and the output AXI-Stream DMA. It accepts ROWS signed Y_BITS results per beat and casts each to 1, 2 or 4 bytes (saturate when narrowing, sign-extend when widening). It packs the cast bytes densely into AXI_WIDTH beats and flushes a partial, tkeep-masked final beat on packet end. It replaces the fixed sign-pad + generic width-adapter output path.

---
 rtl/out_pack_pkg.sv | 26 ++
 rtl/sat_cast.sv | 36 +++
 rtl/axis_out_packer.sv | 133 +++++++++++++
 tb/tb_axis_out_packer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_pack_pkg.sv
// Shared definitions for the AXI-Stream output packer: element size
// encodings and helpers for element width and byte buffer capacity.
package out_pack_pkg;

  typedef enum logic [1:0] {
    OUT_B1     = 2'd0,
    OUT_B2     = 2'd1,
    OUT_B4     = 2'd2,
    OUT_B4_ALT = 2'd3
  } out_mode_e;

  // Bytes per output element for a given mode (mode 3 aliases 4 bytes)
  function automatic int mode_bytes(input logic [1:0] mode);
    case (mode)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  // Buffer capacity: one full output beat plus the widest possible input beat
  function automatic int CAP(input int rows, input int ab);
    return ab + 4 * rows;
  endfunction

endpackage

// File: rtl/sat_cast.sv
// Casts one signed Y_BITS element to a 32-bit value that is either
// sign-extended or saturated to the selected output element size.
module sat_cast
  import out_pack_pkg::*;
#(
  parameter int Y_BITS = 24
) (
  input  logic [Y_BITS-1:0] din,
  input  logic [1:0]        mode,
  output logic [31:0]       dout
);

  logic signed [31:0] sx;
  int                 ob;
  int                 hi;
  int                 lo;

  // Saturate only when the output element is narrower than the input's whole bytes
  always_comb begin
    sx   = 32'($signed(din));
    ob   = mode_bytes(mode);
    hi   = 0;
    lo   = 0;
    dout = sx;
    if (ob < Y_BITS / 8) begin
      hi = (1 << (8 * ob - 1)) - 1;
      lo = -hi - 1;
      if (sx > hi) begin
        dout = hi;
      end else if (sx < lo) begin
        dout = lo;
      end
    end
  end

endmodule

// File: rtl/axis_out_packer.sv
// Packs ROWS cast results per input beat densely into AXI_WIDTH output
// beats, flushing a tkeep-masked partial beat at the end of each packet.
module axis_out_packer
  import out_pack_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int Y_BITS    = 24,
  parameter int AXI_WIDTH = 128,
  parameter int W_BPT     = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ROWS*Y_BITS-1:0] s_data,
  input  logic                   s_last,
  input  logic [1:0]             s_mode,
  input  logic [W_BPT-1:0]       s_bytes_per_transfer,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [AXI_WIDTH-1:0]   m_axis_tdata,
  output logic [AXI_WIDTH/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [W_BPT-1:0]       m_bytes_per_transfer
);

  localparam int AB   = AXI_WIDTH / 8;
  localparam int CAPB = CAP(ROWS, AB);
  localparam int FW   = $clog2(CAPB + 1);
  localparam int PW   = 4 * ROWS;

  localparam logic [FW-1:0] AB_F = FW'(AB);
  localparam logic [FW-1:0] PB1  = FW'(ROWS);
  localparam logic [FW-1:0] PB2  = FW'(2 * ROWS);
  localparam logic [FW-1:0] PB4  = FW'(4 * ROWS);

  // Bytes at or above fill are always kept zero so new data can be OR-ed in
  logic [CAPB*8-1:0] byte_buf;
  logic [CAPB*8-1:0] buf_next;
  logic [FW-1:0]     fill;
  logic [FW-1:0]     fill_next;
  logic [FW-1:0]     pop_bytes;
  logic [FW-1:0]     push_bytes;
  logic [FW-1:0]     wr_off;
  logic              flush;
  logic              first;
  logic [1:0]        mode_q;
  logic [W_BPT-1:0]  bpt_q;
  out_mode_e         mode_sel;
  logic [31:0]       cast_val [ROWS];
  logic [PW*8-1:0]   packed_bytes;
  logic              push;
  logic              pop;

  assign s_ready              = !flush && (fill <= AB_F);
  assign m_axis_tvalid        = (fill >= AB_F) || (flush && (fill != '0));
  assign m_axis_tdata         = byte_buf[AXI_WIDTH-1:0];
  assign m_axis_tkeep         = (fill >= AB_F) ? '1 : ~({AB{1'b1}} << fill);
  assign m_axis_tlast         = flush && (fill <= AB_F);
  assign m_bytes_per_transfer = bpt_q;
  assign push                 = s_valid && s_ready;
  assign pop                  = m_axis_tvalid && m_axis_tready;
  assign mode_sel             = out_mode_e'(first ? s_mode : mode_q);

  for (genvar i = 0; i < ROWS; i++) begin : g_cast
    sat_cast #(
      .Y_BITS(Y_BITS)
    ) u_cast (
      .din (s_data[Y_BITS*i +: Y_BITS]),
      .mode(mode_sel),
      .dout(cast_val[i])
    );
  end

  // Pack the cast elements densely, element 0 in the lowest byte
  always_comb begin
    packed_bytes = '0;
    push_bytes   = PB4;
    case (mode_sel)
      OUT_B1: begin
        push_bytes = PB1;
        for (int i = 0; i < ROWS; i++) packed_bytes[i*8 +: 8] = cast_val[i][7:0];
      end
      OUT_B2: begin
        push_bytes = PB2;
        for (int i = 0; i < ROWS; i++) packed_bytes[i*16 +: 16] = cast_val[i][15:0];
      end
      default: begin
        push_bytes = PB4;
        for (int i = 0; i < ROWS; i++) packed_bytes[i*32 +: 32] = cast_val[i];
      end
    endcase
  end

  // Pop first, then append the new beat right after the surviving bytes
  always_comb begin
    pop_bytes = '0;
    if (pop) pop_bytes = (fill >= AB_F) ? AB_F : fill;
    wr_off    = fill - pop_bytes;
    buf_next  = byte_buf >> {pop_bytes, 3'b000};
    fill_next = fill - pop_bytes;
    if (push) begin
      buf_next  = buf_next | ({{(AB*8){1'b0}}, packed_bytes} << {wr_off, 3'b000});
      fill_next = fill_next + push_bytes;
    end
  end

  // Buffer, fill and packet flags; the tlast pop re-arms mode/bpt latching
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      byte_buf <= '0;
      fill     <= '0;
      flush    <= 1'b0;
      first    <= 1'b1;
      mode_q   <= 2'd0;
      bpt_q    <= '0;
    end else begin
      byte_buf <= buf_next;
      fill     <= fill_next;
      if (push && first) begin
        mode_q <= s_mode;
        bpt_q  <= s_bytes_per_transfer;
        first  <= 1'b0;
      end
      if (push && s_last) flush <= 1'b1;
      if (pop && m_axis_tlast) begin
        flush <= 1'b0;
        first <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_out_packer.sv
// Self-checking bench for axis_out_packer: a byte-queue model of each
// packet predicts every output beat, plus directed literal checks.
module tb_axis_out_packer;

  localparam int ROWS      = 8;
  localparam int Y_BITS    = 24;
  localparam int AXI_WIDTH = 128;
  localparam int W_BPT     = 8;
  localparam int AB        = AXI_WIDTH / 8;

  logic                   aclk;
  logic                   areset;
  logic                   s_valid;
  logic                   s_ready;
  logic [ROWS*Y_BITS-1:0] s_data;
  logic                   s_last;
  logic [1:0]             s_mode;
  logic [W_BPT-1:0]       s_bytes_per_transfer;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic [AXI_WIDTH-1:0]   m_axis_tdata;
  logic [AB-1:0]          m_axis_tkeep;
  logic                   m_axis_tlast;
  logic [W_BPT-1:0]       m_bytes_per_transfer;

  axis_out_packer #(
    .ROWS(ROWS), .Y_BITS(Y_BITS), .AXI_WIDTH(AXI_WIDTH), .W_BPT(W_BPT)
  ) dut (
    .aclk                (aclk),
    .areset              (areset),
    .s_valid             (s_valid),
    .s_ready             (s_ready),
    .s_data              (s_data),
    .s_last              (s_last),
    .s_mode              (s_mode),
    .s_bytes_per_transfer(s_bytes_per_transfer),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tkeep        (m_axis_tkeep),
    .m_axis_tlast        (m_axis_tlast),
    .m_bytes_per_transfer(m_bytes_per_transfer)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [7:0]   bpt;
  } beat_t;

  int          n_cmp;
  int          n_fail;
  int          ready_pct;
  int          pkts_done;
  int          elems [ROWS];
  logic [7:0]  q [$];
  bit          ended;
  bit          mfirst;
  logic [1:0]  pkt_mode;
  logic [7:0]  pkt_bpt;
  beat_t       obs [$];
  bit          have_stall;
  beat_t       stall_beat;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Append the cast bytes of one accepted beat to the packet's byte queue
  function automatic void model_push(input logic [ROWS*Y_BITS-1:0] d, input logic [1:0] mode);
    int     ob;
    longint v;
    longint hi;
    ob = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
    for (int i = 0; i < ROWS; i++) begin
      v = longint'($signed(d[i*Y_BITS +: Y_BITS]));
      if (ob < Y_BITS / 8) begin
        hi = (longint'(1) << (8 * ob - 1)) - 1;
        if (v > hi) v = hi;
        if (v < -hi - 1) v = -hi - 1;
      end
      for (int b = 0; b < ob; b++) q.push_back(8'(v >>> (8 * b)));
    end
  endfunction

  function automatic logic [ROWS*Y_BITS-1:0] pack_elems();
    logic [ROWS*Y_BITS-1:0] r;
    for (int i = 0; i < ROWS; i++) r[i*Y_BITS +: Y_BITS] = 24'(elems[i]);
    return r;
  endfunction

  // Random output back-pressure, changed once per cycle
  always @(posedge aclk) begin
    #1;
    m_axis_tready = (int'($urandom_range(0, 99)) < ready_pct);
  end

  // Compare process: checks outputs against the byte-queue model every cycle
  always @(negedge aclk) begin
    int           n;
    int           k;
    logic [127:0] ed;
    logic [127:0] emask;
    logic [15:0]  ek;
    logic         el;
    if (areset) begin
      q.delete();
      ended      = 1'b0;
      mfirst     = 1'b1;
      have_stall = 1'b0;
    end else begin
      if (have_stall) begin
        check_output("stall_tvalid", 128'(m_axis_tvalid), 128'(1'b1));
        check_output("stall_tdata", m_axis_tdata, stall_beat.data);
        check_output("stall_tkeep", 128'(m_axis_tkeep), 128'(stall_beat.keep));
        check_output("stall_tlast", 128'(m_axis_tlast), 128'(stall_beat.last));
      end
      n = q.size();
      check_output("tvalid", 128'(m_axis_tvalid), 128'((n >= AB) || (ended && n > 0)));
      check_output("s_ready", 128'(s_ready), 128'(!ended && n <= AB));
      if (m_axis_tvalid && n > 0) begin
        k     = (n >= AB) ? AB : n;
        ed    = '0;
        emask = '0;
        ek    = '0;
        for (int j = 0; j < k; j++) begin
          ed[8*j +: 8]    = q[j];
          emask[8*j +: 8] = 8'hFF;
          ek[j]           = 1'b1;
        end
        el = ended && (n <= AB);
        check_output("tdata", m_axis_tdata & emask, ed);
        check_output("tkeep", 128'(m_axis_tkeep), 128'(ek));
        check_output("tlast", 128'(m_axis_tlast), 128'(el));
        check_output("bpt", 128'(m_bytes_per_transfer), 128'(pkt_bpt));
        if (m_axis_tready) begin
          obs.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_bytes_per_transfer});
          for (int j = 0; j < k; j++) void'(q.pop_front());
          if (el) begin
            ended  = 1'b0;
            mfirst = 1'b1;
            pkts_done++;
          end
        end
      end
      have_stall = m_axis_tvalid && !m_axis_tready;
      stall_beat = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_bytes_per_transfer};
      if (s_valid && s_ready) begin
        if (mfirst) begin
          pkt_mode = s_mode;
          pkt_bpt  = s_bytes_per_transfer;
          mfirst   = 1'b0;
        end
        model_push(s_data, pkt_mode);
        if (s_last) ended = 1'b1;
      end
    end
  end

  // Present one beat and hold it until accepted (bounded)
  task automatic apply_stimulus(input logic [ROWS*Y_BITS-1:0] d, input logic [1:0] mode,
                                input logic [7:0] bpt, input logic last);
    bit accepted;
    accepted             = 1'b0;
    s_valid              = 1'b1;
    s_data               = d;
    s_mode               = mode;
    s_bytes_per_transfer = bpt;
    s_last               = last;
    for (int c = 0; c < 500 && !accepted; c++) begin
      @(negedge aclk);
      if (s_ready) accepted = 1'b1;
    end
    check_output("accept_timeout", 128'(accepted), 128'(1'b1));
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_packets(input int target);
    for (int c = 0; c < 3000 && pkts_done < target; c++) @(posedge aclk);
    check_output("packet_timeout", 128'(pkts_done), 128'(target));
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int target;
    int nb;
    logic [1:0] pm;
    n_cmp = 0; n_fail = 0; pkts_done = 0; ready_pct = 100;
    areset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_mode = 2'd0;
    s_data = '0; s_bytes_per_transfer = '0; m_axis_tready = 1'b0;
    ended = 1'b0; mfirst = 1'b1; have_stall = 1'b0; pkt_mode = 2'd0; pkt_bpt = '0;
    #2;
    check_output("rst_s_ready", 128'(s_ready), 128'(1'b1));
    check_output("rst_tvalid", 128'(m_axis_tvalid), 128'(1'b0));
    check_output("rst_tdata", m_axis_tdata, 128'h0);
    check_output("rst_tkeep", 128'(m_axis_tkeep), 128'h0);
    check_output("rst_tlast", 128'(m_axis_tlast), 128'(1'b0));
    check_output("rst_bpt", 128'(m_bytes_per_transfer), 128'h0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;

    // Mode 0, values 1..32 over four beats
    obs.delete(); target = pkts_done + 1;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < ROWS; i++) elems[i] = 8 * b + i + 1;
      apply_stimulus(pack_elems(), 2'd0, 8'h11, b == 3);
    end
    wait_packets(target);
    check_output("t1_beats", 128'(obs.size()), 128'd2);
    if (obs.size() == 2) begin
      check_output("t1_data0", obs[0].data, 128'h100f0e0d0c0b0a090807060504030201);
      check_output("t1_data1", obs[1].data, 128'h201f1e1d1c1b1a191817161514131211);
      check_output("t1_keep1", 128'(obs[1].keep), 128'hFFFF);
      check_output("t1_last0", 128'(obs[0].last), 128'h0);
      check_output("t1_last1", 128'(obs[1].last), 128'h1);
      check_output("t1_bpt", 128'(obs[1].bpt), 128'h11);
    end

    // Mode 2 sign extension
    obs.delete(); target = pkts_done + 1;
    elems[0] = 32'h00FF_FFFF;
    for (int i = 1; i < ROWS; i++) elems[i] = i;
    apply_stimulus(pack_elems(), 2'd2, 8'h22, 1'b1);
    wait_packets(target);
    check_output("t2_beats", 128'(obs.size()), 128'd2);
    if (obs.size() == 2) begin
      check_output("t2_data0", obs[0].data, 128'h00000003_00000002_00000001_ffffffff);
      check_output("t2_data1", obs[1].data, 128'h00000007_00000006_00000005_00000004);
      check_output("t2_last1", 128'(obs[1].last), 128'h1);
    end

    // Mode 0 saturation
    obs.delete(); target = pkts_done + 1;
    elems[0] = 32'h000100; elems[1] = 32'hFFFE00; elems[2] = 32'h00007F; elems[3] = 32'hFFFF80;
    for (int i = 4; i < ROWS; i++) elems[i] = 0;
    apply_stimulus(pack_elems(), 2'd0, 8'h33, 1'b1);
    wait_packets(target);
    check_output("t3_beats", 128'(obs.size()), 128'd1);
    if (obs.size() == 1) begin
      check_output("t3_sat", 128'(obs[0].data[31:0]), 128'h807F807F);
      check_output("t3_keep", 128'(obs[0].keep), 128'h00FF);
      check_output("t3_last", 128'(obs[0].last), 128'h1);
    end

    // Mode 1: three beats, then a single-beat packet
    obs.delete(); target = pkts_done + 1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < ROWS; i++) elems[i] = int'($urandom);
      apply_stimulus(pack_elems(), 2'd1, 8'h44, b == 2);
    end
    wait_packets(target);
    check_output("t4_beats", 128'(obs.size()), 128'd3);
    if (obs.size() == 3) begin
      check_output("t4_keep2", 128'(obs[2].keep), 128'hFFFF);
      check_output("t4_lasts", 128'({obs[0].last, obs[1].last, obs[2].last}), 128'b001);
    end
    obs.delete(); target = pkts_done + 1;
    apply_stimulus(pack_elems(), 2'd1, 8'h45, 1'b1);
    wait_packets(target);
    check_output("t4b_beats", 128'(obs.size()), 128'd1);
    if (obs.size() == 1) check_output("t4b_last", 128'(obs[0].last), 128'h1);

    // Mode 0 with back-pressure and an ignored mode change
    obs.delete(); target = pkts_done + 1; ready_pct = 50;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < ROWS; i++) elems[i] = int'($urandom);
      apply_stimulus(pack_elems(), (b == 1) ? 2'd2 : 2'd0, 8'h55, b == 2);
    end
    wait_packets(target);
    check_output("t5_beats", 128'(obs.size()), 128'd2);
    if (obs.size() == 2) begin
      check_output("t5_keep0", 128'(obs[0].keep), 128'hFFFF);
      check_output("t5_keep1", 128'(obs[1].keep), 128'h00FF);
      check_output("t5_last1", 128'(obs[1].last), 128'h1);
    end

    // Reset mid-packet with 8 bytes buffered
    ready_pct = 100;
    apply_stimulus(pack_elems(), 2'd0, 8'h66, 1'b0);
    areset = 1'b1;
    #1;
    check_output("mid_rst_s_ready", 128'(s_ready), 128'(1'b1));
    check_output("mid_rst_tvalid", 128'(m_axis_tvalid), 128'(1'b0));
    check_output("mid_rst_tdata", m_axis_tdata, 128'h0);
    check_output("mid_rst_tkeep", 128'(m_axis_tkeep), 128'h0);
    check_output("mid_rst_bpt", 128'(m_bytes_per_transfer), 128'h0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    obs.delete(); target = pkts_done + 1;
    for (int i = 0; i < ROWS; i++) elems[i] = -i;
    apply_stimulus(pack_elems(), 2'd2, 8'h5A, 1'b1);
    wait_packets(target);
    check_output("t6_beats", 128'(obs.size()), 128'd2);
    if (obs.size() == 2) begin
      check_output("t6_bpt", 128'(obs[0].bpt), 128'h5A);
      check_output("t6_data0", obs[0].data, 128'hfffffffd_fffffffe_ffffffff_00000000);
    end

    // Randomized packets
    for (int p = 0; p < 30; p++) begin
      ready_pct = int'($urandom_range(30, 100));
      nb = int'($urandom_range(1, 6));
      pm = 2'($urandom_range(0, 3));
      target = pkts_done + 1;
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < ROWS; i++) begin
          case ($urandom_range(0, 3))
            0: elems[i] = int'($urandom_range(0, 255));
            1: elems[i] = -int'($urandom_range(0, 40000));
            2: elems[i] = ($urandom_range(0, 1) == 1) ? 32'h7FFFFF : 32'h800000;
            default: elems[i] = int'($urandom);
          endcase
        end
        apply_stimulus(pack_elems(), (b == 0) ? pm : 2'($urandom_range(0, 3)),
                       8'($urandom), b == nb - 1);
        idle(int'($urandom_range(0, 2)));
      end
      wait_packets(target);
    end

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
